// File: rtl/pgm_loader_pkg.sv
// Purpose: shared types and constants for the program-image boot loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: byte width, byte type, loader FSM state encoding, state-class helper.
package pgm_loader_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // True in the states that accept image bytes and run the idle timer.
    function automatic logic is_loading(input state_t s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/pgm_loader_timer.sv
// Purpose: idle-cycle watchdog; counts cycles while run=1, restarts on clr.
// Latency: expire is combinational from the count, asserted on the cycle whose edge reaches LIMIT.
// Backpressure: none; LIMIT=0 disables expiry entirely.
// Ports: clk, reset (async active-low), clr (restart count), run (count this cycle),
//        expire (this edge completes LIMIT idle cycles).
module pgm_loader_timer #(
    parameter int           W     = 16,
    parameter logic [W-1:0] LIMIT = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expire
);

    logic [W-1:0] cnt_q;
    logic [W:0]   cnt_inc;
    logic         enabled;

    assign enabled = (LIMIT != '0);
    assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    // Fires on the edge at which the count would become LIMIT.
    assign expire  = enabled && run && (cnt_inc == {1'b0, LIMIT});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || expire) begin
            cnt_q <= '0;
        end else if (run && enabled) begin
            cnt_q <= cnt_inc[W-1:0];
        end
    end

endmodule

// File: rtl/pgm_loader.sv
// Purpose: loads a length-prefixed, checksummed byte image into program memory and
//          holds the CPU in reset until an image has loaded and verified.
// Latency: a data byte accepted on edge k is written to memory during cycle k+1; status updates on the CSUM edge.
// Backpressure: in_ready is registered and high only in LEN/DATA/CSUM; no internal stalls while loading.
// Ports: clk, reset (async active-low), start (load request), in_valid/in_data/in_ready (byte stream),
//        pm_we/pm_addr/pm_wdata (memory write), cpu_hold, done, error (status of the last load).
module pgm_loader
    import pgm_loader_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              pm_we,
    output logic [BYTE_W-1:0] pm_addr,
    output logic [BYTE_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t state_q, state_d;

    // Length and index are 9 bits so that LEN=0 can represent a 256-byte image.
    logic [8:0] len_q, len_d;
    logic [8:0] idx_q, idx_d;
    byte_t      sum_q, sum_d;

    logic       in_ready_q, in_ready_d;
    logic       pm_we_q, pm_we_d;
    byte_t      pm_addr_q, pm_addr_d;
    byte_t      pm_wdata_q, pm_wdata_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic       xfer;
    logic       loading;
    logic       tmo_expire;
    logic [8:0] idx_inc;
    byte_t      sum_next;

    assign xfer     = in_valid && in_ready_q;
    assign loading  = is_loading(state_q);
    assign idx_inc  = idx_q + 9'd1;
    assign sum_next = sum_q + in_data;

    // The timer only counts idle cycles inside a load; any transfer or leaving
    // the load states restarts it.
    pgm_loader_timer #(
        .W     (16),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (!loading || xfer),
        .run    (loading && !xfer),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (xfer) begin
                    len_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    idx_d   = 9'd0;
                    sum_d   = 8'd0;
                    state_d = S_DATA;
                end else if (tmo_expire) begin
                    state_d = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    sum_d      = sum_next;
                    pm_we_d    = 1'b1;
                    // 8-bit add: the address wraps silently past 8'hFF.
                    pm_addr_d  = BASE_ADDR + idx_q[7:0];
                    pm_wdata_d = in_data;
                    idx_d      = idx_inc;
                    if (idx_inc == len_q) state_d = S_CSUM;
                end else if (tmo_expire) begin
                    state_d = S_ERR;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (sum_next == 8'd0) ? S_DONE : S_ERR;
                end else if (tmo_expire) begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start) state_d = S_LEN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags follow the next state, so entering LEN from DONE/ERR
        // clears done/error and re-asserts cpu_hold on the same edge.
        in_ready_d = is_loading(state_d);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= 9'd0;
            idx_q      <= 9'd0;
            sum_q      <= 8'd0;
            in_ready_q <= 1'b0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= BASE_ADDR;
            pm_wdata_q <= 8'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            in_ready_q <= in_ready_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign pm_we    = pm_we_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_pgm_loader.sv
// Purpose: self-checking bench for pgm_loader with two instances (base 00/timeout 10, base FE/no timeout).
// Latency: write expectations are exact per cycle: a data transfer on edge k must write in cycle k+1 only.
// Backpressure: bytes are held stable until in_ready; random idle gaps and stray start pulses are injected.
module tb_pgm_loader;

    localparam logic [7:0] BASE0 = 8'h00;
    localparam logic [7:0] BASE1 = 8'hFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start    [2];
    logic       in_valid [2];
    logic [7:0] in_data  [2];
    logic       in_ready [2];
    logic       pm_we    [2];
    logic [7:0] pm_addr  [2];
    logic [7:0] pm_wdata [2];
    logic       cpu_hold [2];
    logic       done     [2];
    logic       error    [2];

    int n_checks = 0;
    int n_errors = 0;

    // What the driver is currently presenting: is it an image data byte, and where must it land.
    logic       drv_is_data [2];
    logic [7:0] drv_addr    [2];
    // Expected memory write for the current cycle, derived from the previous edge's transfer.
    logic       exp_we   [2];
    logic [7:0] exp_addr [2];
    logic [7:0] exp_dat  [2];

    logic [7:0] img [256];

    pgm_loader #(.BASE_ADDR(BASE0), .TIMEOUT(16'd10)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .pm_we(pm_we[0]), .pm_addr(pm_addr[0]), .pm_wdata(pm_wdata[0]),
        .cpu_hold(cpu_hold[0]), .done(done[0]), .error(error[0])
    );

    pgm_loader #(.BASE_ADDR(BASE1), .TIMEOUT(16'd0)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .pm_we(pm_we[1]), .pm_addr(pm_addr[1]), .pm_wdata(pm_wdata[1]),
        .cpu_hold(cpu_hold[1]), .done(done[1]), .error(error[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] base_of(input int u);
        return (u == 0) ? BASE0 : BASE1;
    endfunction

    function automatic logic [7:0] csum_of(input int n);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < n; i++) s = s + img[i];
        return 8'd0 - s;
    endfunction

    // Record the transfer seen on each edge; it becomes the expected write of the following cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) exp_we[u] <= 1'b0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                exp_we[u]   <= in_valid[u] && in_ready[u] && drv_is_data[u];
                exp_addr[u] <= drv_addr[u];
                exp_dat[u]  <= in_data[u];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d_pm_we", u), pm_we[u], exp_we[u]);
                if (exp_we[u]) begin
                    check($sformatf("u%0d_pm_addr", u), pm_addr[u], exp_addr[u]);
                    check($sformatf("u%0d_pm_wdata", u), pm_wdata[u], exp_dat[u]);
                end
            end
        end
    end

    task automatic idle_inputs(input int u);
        in_valid[u]    = 1'b0;
        start[u]       = 1'b0;
        drv_is_data[u] = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge following the transfer edge.
    task automatic send_byte(input int u, input logic [7:0] b, input logic is_data,
                             input logic [7:0] addr, input int gap_max, input logic noise);
        int g = int'($urandom_range(gap_max, 0));
        int tries = 0;
        repeat (g) begin
            idle_inputs(u);
            @(negedge clk);
        end
        in_valid[u]    = 1'b1;
        in_data[u]     = b;
        drv_is_data[u] = is_data;
        drv_addr[u]    = addr;
        start[u]       = noise && ($urandom_range(1, 0) == 1);
        while (!in_ready[u] && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready[u]) check($sformatf("u%0d_ready_wait", u), in_ready[u], 1);
        @(negedge clk);
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        check($sformatf("u%0d_start_hold", u), cpu_hold[u], 1);
        check($sformatf("u%0d_start_done", u), done[u], 0);
        check($sformatf("u%0d_start_err", u), error[u], 0);
        check($sformatf("u%0d_start_rdy", u), in_ready[u], 1);
    endtask

    // Full image from img[0..n-1]; status expectation comes from the checksum rule.
    task automatic load_image(input int u, input int n, input logic [7:0] csum,
                              input int gap_max, input logic noise);
        logic [7:0] s = 8'd0;
        logic       ok;
        pulse_start(u);
        send_byte(u, 8'(n), 1'b0, 8'h00, gap_max, noise);
        for (int i = 0; i < n; i++) begin
            send_byte(u, img[i], 1'b1, base_of(u) + 8'(i), gap_max, noise);
            s = s + img[i];
        end
        send_byte(u, csum, 1'b0, 8'h00, gap_max, noise);
        idle_inputs(u);
        ok = ((s + csum) == 8'd0);
        check($sformatf("u%0d_done", u), done[u], ok);
        check($sformatf("u%0d_error", u), error[u], !ok);
        check($sformatf("u%0d_cpu_hold", u), cpu_hold[u], !ok);
        check($sformatf("u%0d_end_rdy", u), in_ready[u], 0);
    endtask

    task automatic check_reset_vals(input int u);
        check($sformatf("u%0d_rst_rdy", u), in_ready[u], 0);
        check($sformatf("u%0d_rst_we", u), pm_we[u], 0);
        check($sformatf("u%0d_rst_addr", u), pm_addr[u], base_of(u));
        check($sformatf("u%0d_rst_wdata", u), pm_wdata[u], 0);
        check($sformatf("u%0d_rst_hold", u), cpu_hold[u], 1);
        check($sformatf("u%0d_rst_done", u), done[u], 0);
        check($sformatf("u%0d_rst_err", u), error[u], 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] cs;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            idle_inputs(u);
            in_data[u]  = 8'h00;
            drv_addr[u] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("u0_idle_ignores_valid", in_ready[0], 0);

        // Directed image, back-to-back: good, bad checksum, good again with gaps.
        img[0] = 8'hD0; img[1] = 8'h0A; img[2] = 8'h90;
        load_image(0, 3, 8'h96, 0, 1'b0);
        load_image(0, 3, 8'h97, 0, 1'b0);
        load_image(0, 3, 8'h96, 2, 1'b0);

        // Address wrap at base FE.
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
        load_image(1, 3, csum_of(3), 0, 1'b0);

        // Idle timeout after LEN=2 and one data byte.
        pulse_start(0);
        send_byte(0, 8'd2, 1'b0, 8'h00, 0, 1'b0);
        send_byte(0, 8'h5A, 1'b1, BASE0, 0, 1'b0);
        idle_inputs(0);
        repeat (9) @(negedge clk);
        check("tmo_early_err", error[0], 0);
        check("tmo_early_rdy", in_ready[0], 1);
        @(negedge clk);
        check("tmo_err", error[0], 1);
        check("tmo_done", done[0], 0);
        check("tmo_hold", cpu_hold[0], 1);
        check("tmo_rdy", in_ready[0], 0);

        // Timeout disabled on the second instance: a long stall is harmless.
        img[0] = 8'h42; img[1] = 8'hC3;
        pulse_start(1);
        send_byte(1, 8'd2, 1'b0, 8'h00, 0, 1'b0);
        send_byte(1, img[0], 1'b1, BASE1, 0, 1'b0);
        idle_inputs(1);
        repeat (40) @(negedge clk);
        check("notmo_err", error[1], 0);
        check("notmo_rdy", in_ready[1], 1);
        send_byte(1, img[1], 1'b1, BASE1 + 8'd1, 0, 1'b0);
        send_byte(1, csum_of(2), 1'b0, 8'h00, 0, 1'b0);
        idle_inputs(1);
        check("notmo_done", done[1], 1);

        // Random images with random gaps, stray start pulses and occasional bad checksums.
        for (int t = 0; t < 10; t++) begin
            n = int'($urandom_range(24, 1));
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            cs = csum_of(n);
            if ($urandom_range(3, 0) == 0) cs = cs + 8'($urandom_range(255, 1));
            load_image(t % 2, n, cs, 1, 1'b1);
        end

        // Full 256-byte images (LEN=0); the FE instance wraps through the whole space.
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        load_image(1, 256, csum_of(256), 1, 1'b0);
        load_image(0, 256, csum_of(256), 0, 1'b0);

        // Reset in the middle of DATA, then a clean reload.
        for (int i = 0; i < 5; i++) img[i] = 8'($urandom);
        pulse_start(0);
        send_byte(0, 8'd5, 1'b0, 8'h00, 0, 1'b0);
        send_byte(0, img[0], 1'b1, BASE0, 0, 1'b0);
        send_byte(0, img[1], 1'b1, BASE0 + 8'd1, 0, 1'b0);
        idle_inputs(0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_image(0, 5, csum_of(5), 1, 1'b0);
        load_image(1, 5, csum_of(5), 1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
